// File: rtl/frv_timer_bank_pkg.sv
// Shared definitions for the timer bank: register map offsets, CTRL bit
// positions, channel geometry and the CTRL read-back helper.
package frv_timer_bank_pkg;

  localparam int MAX_NCMP  = 8;
  localparam int CH_STRIDE = 16;

  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_0004;
  localparam logic [31:0] OFF_PRESCALE = 32'h0000_0008;
  localparam logic [31:0] OFF_STATUS   = 32'h0000_000C;
  localparam logic [31:0] OFF_CH_BASE  = 32'h0000_0010;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;

  typedef enum logic [1:0] {
    CH_CMP_LO = 2'd0,
    CH_CMP_HI = 2'd1,
    CH_CTRL   = 2'd2,
    CH_PERIOD = 2'd3
  } ch_reg_e;

  function automatic logic [31:0] ctrl_word(input logic en, input logic periodic);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_EN]       = en;
    w[CTRL_PERIODIC] = periodic;
    return w;
  endfunction

endpackage

// File: rtl/frv_timer_bank_if.sv
// MMIO bus between the core's peripheral port (master) and the timer bank (slave).
interface frv_timer_bank_if;
  logic        mmio_en;
  logic        mmio_wen;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_error;

  modport master (
    output mmio_en, mmio_wen, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_error
  );

  modport slave (
    input  mmio_en, mmio_wen, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_error
  );
endinterface

// File: rtl/frv_timer_bank_cmp.sv
// One compare channel: cmp/CTRL/PERIOD registers, sticky pending bit and the
// registered interrupt line.
module frv_timer_cmp
  import frv_timer_bank_pkg::*;
#(
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter logic        EN_RESET  = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [63:0] i_mtime,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic        i_wr_ctrl,
  input  logic        i_wr_period,
  input  logic [31:0] i_wdata,
  input  logic        i_w1c,
  output logic [63:0] o_cmp,
  output logic        o_en,
  output logic        o_periodic,
  output logic [31:0] o_period,
  output logic        o_pending,
  output logic        o_irq
);

  logic [63:0] r_cmp;
  logic        r_en;
  logic        r_periodic;
  logic [31:0] r_period;
  logic        r_pending;
  logic        r_irq;

  logic        w_match;
  logic [63:0] w_cmp_nxt;
  logic        w_pend_nxt;
  logic        w_en_nxt;

  // A CMP write suppresses this cycle's set/reload; a set beats a W1C clear.
  always_comb begin
    w_match    = r_en && (i_mtime >= r_cmp);
    w_cmp_nxt  = r_cmp;
    w_pend_nxt = r_pending;
    w_en_nxt   = r_en;
    if (i_wr_lo) begin
      w_cmp_nxt = {r_cmp[63:32], i_wdata};
    end else if (i_wr_hi) begin
      w_cmp_nxt = {i_wdata, r_cmp[31:0]};
    end else if (w_match && r_periodic) begin
      w_cmp_nxt = r_cmp + {32'd0, r_period};
    end else begin
      w_cmp_nxt = r_cmp;
    end
    if (i_wr_lo || i_wr_hi) begin
      w_pend_nxt = 1'b0;
    end else if (w_match) begin
      w_pend_nxt = 1'b1;
    end else if (i_w1c) begin
      w_pend_nxt = 1'b0;
    end else begin
      w_pend_nxt = r_pending;
    end
    if (i_wr_ctrl) begin
      w_en_nxt = i_wdata[CTRL_EN];
    end else begin
      w_en_nxt = r_en;
    end
  end

  // Channel state registers; the interrupt is registered from next-state values.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cmp      <= CMP_RESET;
      r_en       <= EN_RESET;
      r_periodic <= 1'b0;
      r_period   <= 32'd0;
      r_pending  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_cmp     <= w_cmp_nxt;
      r_en      <= w_en_nxt;
      r_pending <= w_pend_nxt;
      r_irq     <= w_pend_nxt && w_en_nxt;
      if (i_wr_ctrl) r_periodic <= i_wdata[CTRL_PERIODIC];
      if (i_wr_period) r_period <= i_wdata;
    end
  end

  assign o_cmp      = r_cmp;
  assign o_en       = r_en;
  assign o_periodic = r_periodic;
  assign o_period   = r_period;
  assign o_pending  = r_pending;
  assign o_irq      = r_irq;

endmodule

// File: rtl/frv_timer_bank.sv
// Timer bank top: mtime with prescaler, NCMP compare channels, cycle/instret
// counters and the MMIO decode/read path.
module frv_timer_bank
  import frv_timer_bank_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE_ADDR      = 32'h0000_1000,
  parameter logic [31:0] MMIO_BASE_MASK      = 32'hFFFF_F000,
  parameter int          NCMP                = 2,
  parameter int          PRESCALE_W          = 8,
  parameter logic [63:0] MMIO_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              instr_ret,
  input  logic              inhibit_cy,
  input  logic              inhibit_tm,
  input  logic              inhibit_ir,
  frv_timer_bank_if.slave   mmio,
  output logic [NCMP-1:0]   timer_interrupt,
  output logic [63:0]       ctr_time,
  output logic [63:0]       ctr_cycle,
  output logic [63:0]       ctr_instret
);

  logic [63:0]           r_mtime;
  logic [PRESCALE_W-1:0] r_pc;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [63:0]           r_cycle;
  logic [63:0]           r_instret;
  logic [31:0]           r_rdata;
  logic                  r_error;

  logic [31:0] w_off;
  logic        w_in_win;
  logic        w_aligned;
  logic [27:0] w_slot;
  logic        w_is_ch;
  logic [2:0]  w_ch_sel;
  ch_reg_e     w_ch_reg;
  logic        w_sel_mlo, w_sel_mhi, w_sel_pre, w_sel_stat;
  logic        w_err;
  logic        w_wr;
  logic        w_tick;
  logic [31:0] w_rd;

  logic [MAX_NCMP-1:0][63:0] w_cmp;
  logic [MAX_NCMP-1:0][31:0] w_period;
  logic [MAX_NCMP-1:0]       w_en;
  logic [MAX_NCMP-1:0]       w_periodic;
  logic [MAX_NCMP-1:0]       w_pending;

  assign w_off      = mmio.mmio_addr & ~MMIO_BASE_MASK;
  assign w_in_win   = (mmio.mmio_addr & MMIO_BASE_MASK) == (MMIO_BASE_ADDR & MMIO_BASE_MASK);
  assign w_aligned  = (w_off[1:0] == 2'b00);
  // Offsets below the channel block underflow and fall outside the channel range.
  assign w_slot     = w_off[31:4] - OFF_CH_BASE[31:4];
  assign w_is_ch    = (w_slot < 28'(NCMP));
  assign w_ch_sel   = w_slot[2:0];
  assign w_ch_reg   = ch_reg_e'(w_off[3:2]);
  assign w_sel_mlo  = (w_off[31:2] == OFF_MTIME_LO[31:2]);
  assign w_sel_mhi  = (w_off[31:2] == OFF_MTIME_HI[31:2]);
  assign w_sel_pre  = (w_off[31:2] == OFF_PRESCALE[31:2]);
  assign w_sel_stat = (w_off[31:2] == OFF_STATUS[31:2]);
  assign w_err      = !(w_in_win && w_aligned && (w_sel_mlo || w_sel_mhi || w_sel_pre || w_sel_stat || w_is_ch));
  assign w_wr       = mmio.mmio_en && mmio.mmio_wen && !w_err;
  assign w_tick     = (r_pc == r_prescale) && !inhibit_tm;

  for (genvar gi = 0; gi < MAX_NCMP; gi++) begin : g_ch
    if (gi < NCMP) begin : g_on
      logic w_hit;
      assign w_hit = w_wr && w_is_ch && (w_ch_sel == 3'(gi));
      frv_timer_cmp #(
        .CMP_RESET (MMIO_MTIMECMP_RESET),
        .EN_RESET  ((gi == 0) ? 1'b1 : 1'b0)
      ) u_cmp (
        .i_clk       (g_clk),
        .i_rstn      (g_resetn),
        .i_mtime     (r_mtime),
        .i_wr_lo     (w_hit && (w_ch_reg == CH_CMP_LO)),
        .i_wr_hi     (w_hit && (w_ch_reg == CH_CMP_HI)),
        .i_wr_ctrl   (w_hit && (w_ch_reg == CH_CTRL)),
        .i_wr_period (w_hit && (w_ch_reg == CH_PERIOD)),
        .i_wdata     (mmio.mmio_wdata),
        .i_w1c       (w_wr && w_sel_stat && mmio.mmio_wdata[gi]),
        .o_cmp       (w_cmp[gi]),
        .o_en        (w_en[gi]),
        .o_periodic  (w_periodic[gi]),
        .o_period    (w_period[gi]),
        .o_pending   (w_pending[gi]),
        .o_irq       (timer_interrupt[gi])
      );
    end else begin : g_off
      assign w_cmp[gi]      = 64'd0;
      assign w_period[gi]   = 32'd0;
      assign w_en[gi]       = 1'b0;
      assign w_periodic[gi] = 1'b0;
      assign w_pending[gi]  = 1'b0;
    end
  end

  // Read mux: pre-write register state, zero on a decode error.
  always_comb begin
    w_rd = 32'd0;
    if (w_err) begin
      w_rd = 32'd0;
    end else if (w_sel_mlo) begin
      w_rd = r_mtime[31:0];
    end else if (w_sel_mhi) begin
      w_rd = r_mtime[63:32];
    end else if (w_sel_pre) begin
      w_rd = 32'(r_prescale);
    end else if (w_sel_stat) begin
      w_rd = 32'(w_pending);
    end else begin
      case (w_ch_reg)
        CH_CMP_LO: w_rd = w_cmp[w_ch_sel][31:0];
        CH_CMP_HI: w_rd = w_cmp[w_ch_sel][63:32];
        CH_CTRL:   w_rd = ctrl_word(w_en[w_ch_sel], w_periodic[w_ch_sel]);
        CH_PERIOD: w_rd = w_period[w_ch_sel];
        default:   w_rd = 32'd0;
      endcase
    end
  end

  // Time base: software writes to mtime beat the tick and restart the prescaler.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_mtime    <= 64'd0;
      r_pc       <= '0;
      r_prescale <= '0;
    end else begin
      if (w_wr && w_sel_mlo) r_mtime[31:0] <= mmio.mmio_wdata;
      else if (w_wr && w_sel_mhi) r_mtime[63:32] <= mmio.mmio_wdata;
      else if (w_tick) r_mtime <= r_mtime + 64'd1;
      if (w_wr && (w_sel_mlo || w_sel_mhi || w_sel_pre)) r_pc <= '0;
      else if (w_tick) r_pc <= '0;
      else if (!inhibit_tm) r_pc <= r_pc + PRESCALE_W'(1);
      if (w_wr && w_sel_pre) r_prescale <= mmio.mmio_wdata[PRESCALE_W-1:0];
    end
  end

  // CSR counters and the registered MMIO response.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_cycle   <= 64'd0;
      r_instret <= 64'd0;
      r_rdata   <= 32'd0;
      r_error   <= 1'b0;
    end else begin
      if (!inhibit_cy) r_cycle <= r_cycle + 64'd1;
      if (instr_ret && !inhibit_ir) r_instret <= r_instret + 64'd1;
      if (mmio.mmio_en) begin
        r_rdata <= w_rd;
        r_error <= w_err;
      end
    end
  end

  assign ctr_time        = r_mtime;
  assign ctr_cycle       = r_cycle;
  assign ctr_instret     = r_instret;
  assign mmio.mmio_rdata = r_rdata;
  assign mmio.mmio_error = r_error;

endmodule

// File: tb/tb_frv_timer_bank.sv
// Scenario bench for frv_timer_bank: read expectations go through a scoreboard
// queue, timing/counter checks are inline in each scenario task.
module tb_frv_timer_bank;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        instr_ret = 1'b0;
  logic        inh_cy = 1'b0;
  logic        inh_tm = 1'b0;
  logic        inh_ir = 1'b0;
  logic [1:0]  irq;
  logic [63:0] t, cyc, ins;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  frv_timer_bank_if bus();

  frv_timer_bank dut (
    .g_clk           (clk),
    .g_resetn        (resetn),
    .instr_ret       (instr_ret),
    .inhibit_cy      (inh_cy),
    .inhibit_tm      (inh_tm),
    .inhibit_ir      (inh_ir),
    .mmio            (bus),
    .timer_interrupt (irq),
    .ctr_time        (t),
    .ctr_cycle       (cyc),
    .ctr_instret     (ins)
  );

  always #5 clk = ~clk;

  // Scoreboard: each read response is compared against the oldest expectation.
  always @(posedge clk) begin
    if (bus.mmio_en === 1'b1 && bus.mmio_wen === 1'b0) begin
      #2;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow: rdata=%h err=%b with no expectation queued", bus.mmio_rdata, bus.mmio_error);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.mmio_rdata !== mon_e.data || bus.mmio_error !== mon_e.err) begin
          n_bad++;
          $display("FAIL %s: rdata=%h err=%b expected rdata=%h err=%b",
                   mon_e.name, bus.mmio_rdata, bus.mmio_error, mon_e.data, mon_e.err);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.mmio_en = 1'b1; bus.mmio_wen = 1'b1; bus.mmio_addr = a; bus.mmio_wdata = d;
    @(negedge clk);
    bus.mmio_en = 1'b0; bus.mmio_wen = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] d, input logic e);
    @(negedge clk);
    sb_q.push_back('{name: name, data: d, err: e});
    bus.mmio_en = 1'b1; bus.mmio_wen = 1'b0; bus.mmio_addr = a;
    @(negedge clk);
    bus.mmio_en = 1'b0;
  endtask

  task automatic wait_time(input logic [63:0] v, input string name);
    for (int k = 0; k < 300; k++) begin
      if (t === v) break;
      @(negedge clk);
    end
    n_cmp++;
    if (t !== v) begin n_bad++; $display("FAIL %s: mtime=%0d never reached %0d", name, t, v); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (t !== 64'd0) begin n_bad++; $display("FAIL rst_time: got %h want 0", t); end
    n_cmp++; if (cyc !== 64'd0 || ins !== 64'd0) begin n_bad++; $display("FAIL rst_ctr: cyc=%h ins=%h want 0", cyc, ins); end
    n_cmp++; if (irq !== 2'b00) begin n_bad++; $display("FAIL rst_irq: got %b want 00", irq); end
    n_cmp++; if (bus.mmio_rdata !== 32'd0 || bus.mmio_error !== 1'b0) begin n_bad++; $display("FAIL rst_bus: rdata=%h err=%b want 0/0", bus.mmio_rdata, bus.mmio_error); end
    resetn = 1'b1; inh_tm = 1'b1;
    rd("rst_mtime_lo", 32'h1000, 32'd0, 1'b0);
    rd("rst_prescale", 32'h1008, 32'd0, 1'b0);
    rd("rst_status",   32'h100C, 32'd0, 1'b0);
    rd("rst_ctrl0",    32'h1018, 32'd1, 1'b0);
    rd("rst_ctrl1",    32'h1028, 32'd0, 1'b0);
    rd("rst_cmp0_lo",  32'h1010, 32'hFFFF_FFFF, 1'b0);
    rd("rst_cmp0_hi",  32'h1014, 32'hFFFF_FFFF, 1'b0);
    rd("rst_period0",  32'h101C, 32'd0, 1'b0);
  endtask

  task automatic test_legacy;
    wr(32'h1010, 32'd10);
    wr(32'h1014, 32'd0);
    wr(32'h1000, 32'd0);
    inh_tm = 1'b0;
    wait_time(64'd10, "legacy_wait");
    n_cmp++; if (irq[0] !== 1'b0) begin n_bad++; $display("FAIL legacy_irq_early: got %b want 0", irq[0]); end
    @(negedge clk);
    n_cmp++; if (irq[0] !== 1'b1) begin n_bad++; $display("FAIL legacy_irq_rise: got %b want 1", irq[0]); end
    wr(32'h1010, 32'd100);
    n_cmp++; if (irq[0] !== 1'b0) begin n_bad++; $display("FAIL legacy_irq_drop: got %b want 0", irq[0]); end
    rd("legacy_status", 32'h100C, 32'd0, 1'b0);
    inh_tm = 1'b1;
  endtask

  task automatic test_prescaler;
    wr(32'h1008, 32'd3);
    wr(32'h1000, 32'd0);
    wr(32'h1004, 32'd0);
    inh_tm = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (t !== 64'd0) begin n_bad++; $display("FAIL pre_3cyc: mtime=%0d want 0", t); end
    @(negedge clk);
    n_cmp++; if (t !== 64'd1) begin n_bad++; $display("FAIL pre_4cyc: mtime=%0d want 1", t); end
    repeat (4) @(negedge clk);
    n_cmp++; if (t !== 64'd2) begin n_bad++; $display("FAIL pre_8cyc: mtime=%0d want 2", t); end
    @(negedge clk);
    inh_tm = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (t !== 64'd2) begin n_bad++; $display("FAIL pre_inhibit: mtime=%0d want 2", t); end
    inh_tm = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (t !== 64'd2) begin n_bad++; $display("FAIL pre_pc_held: mtime=%0d want 2", t); end
    @(negedge clk);
    n_cmp++; if (t !== 64'd3) begin n_bad++; $display("FAIL pre_resume: mtime=%0d want 3", t); end
    inh_tm = 1'b1;
    wr(32'h1008, 32'd0);
  endtask

  task automatic test_periodic;
    wr(32'h1018, 32'd0);
    wr(32'h1000, 32'd0);
    wr(32'h102C, 32'd5);
    wr(32'h1020, 32'd20);
    wr(32'h1024, 32'd0);
    wr(32'h1028, 32'd3);
    inh_tm = 1'b0;
    wait_time(64'd20, "per_wait20");
    inh_tm = 1'b1;
    n_cmp++; if (irq[1] !== 1'b0) begin n_bad++; $display("FAIL per_irq_early: got %b want 0", irq[1]); end
    @(negedge clk);
    n_cmp++; if (irq[1] !== 1'b1) begin n_bad++; $display("FAIL per_irq_rise: got %b want 1", irq[1]); end
    rd("per_status",  32'h100C, 32'd2, 1'b0);
    rd("per_cmp_lo",  32'h1020, 32'd25, 1'b0);
    rd("per_cmp_hi",  32'h1024, 32'd0, 1'b0);
    wr(32'h100C, 32'd2);
    n_cmp++; if (irq[1] !== 1'b0) begin n_bad++; $display("FAIL per_w1c_irq: got %b want 0", irq[1]); end
    rd("per_status_clr", 32'h100C, 32'd0, 1'b0);
    inh_tm = 1'b0;
    wait_time(64'd25, "per_wait25");
    inh_tm = 1'b1;
    @(negedge clk);
    n_cmp++; if (irq[1] !== 1'b1) begin n_bad++; $display("FAIL per_repend: got %b want 1", irq[1]); end
    rd("per_cmp_lo2", 32'h1020, 32'd30, 1'b0);
  endtask

  task automatic test_collision;
    wr(32'h1028, 32'd1);
    wr(32'h1000, 32'd30);
    wr(32'h100C, 32'd2);
    n_cmp++; if (irq[1] !== 1'b1) begin n_bad++; $display("FAIL col_w1c_vs_set: irq=%b want 1", irq[1]); end
    rd("col_status", 32'h100C, 32'd2, 1'b0);
    wr(32'h1020, 32'd30);
    n_cmp++; if (irq[1] !== 1'b0) begin n_bad++; $display("FAIL col_cmp_clear: irq=%b want 0", irq[1]); end
    @(negedge clk);
    n_cmp++; if (irq[1] !== 1'b1) begin n_bad++; $display("FAIL col_cmp_next: irq=%b want 1", irq[1]); end
    wr(32'h1028, 32'd0);
    n_cmp++; if (irq[1] !== 1'b0) begin n_bad++; $display("FAIL col_en_mask: irq=%b want 0", irq[1]); end
    rd("col_pend_kept", 32'h100C, 32'd2, 1'b0);
    wr(32'h100C, 32'd2);
    rd("col_pend_clr", 32'h100C, 32'd0, 1'b0);
  endtask

  task automatic test_decode;
    rd("dec_ch9",  32'h10A0, 32'd0, 1'b1);
    rd("dec_misal", 32'h1001, 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.mmio_error !== 1'b1) begin n_bad++; $display("FAIL dec_hold: err=%b want 1", bus.mmio_error); end
    rd("dec_ok_after", 32'h1010, 32'd100, 1'b0);
    wr(32'h1009, 32'h0000_00FF);
    n_cmp++; if (bus.mmio_error !== 1'b1) begin n_bad++; $display("FAIL dec_wr_err: err=%b want 1", bus.mmio_error); end
    wr(32'h1011, 32'h0000_0055);
    wr(32'h1030, 32'h0000_0055);
    rd("dec_pre_kept", 32'h1008, 32'd0, 1'b0);
    rd("dec_cmp_kept", 32'h1010, 32'd100, 1'b0);
    rd("dec_ch2",      32'h1030, 32'd0, 1'b1);
  endtask

  task automatic test_wrap;
    logic [63:0] all1;
    all1 = 64'hFFFF_FFFF_FFFF_FFFF;
    wr(32'h1000, 32'hFFFF_FFFF);
    wr(32'h1004, 32'hFFFF_FFFF);
    n_cmp++; if (t !== all1) begin n_bad++; $display("FAIL wrap_load: mtime=%h want %h", t, all1); end
    inh_tm = 1'b0;
    @(negedge clk);
    inh_tm = 1'b1;
    n_cmp++; if (t !== 64'd0) begin n_bad++; $display("FAIL wrap_zero: mtime=%h want 0", t); end
    rd("wrap_hi", 32'h1004, 32'd0, 1'b0);
  endtask

  task automatic test_counters;
    logic [63:0] expv, cbase;
    @(negedge clk);
    expv = ins;
    for (int i = 0; i < 24; i++) begin
      instr_ret = 1'($urandom_range(0, 1));
      inh_ir = (i % 5 == 2);
      if (instr_ret && !inh_ir) expv = expv + 64'd1;
      @(negedge clk);
    end
    instr_ret = 1'b0; inh_ir = 1'b0;
    n_cmp++; if (ins !== expv) begin n_bad++; $display("FAIL instret: got %0d want %0d", ins, expv); end
    cbase = cyc;
    inh_cy = 1'b1;
    repeat (4) @(negedge clk);
    inh_cy = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (cyc !== cbase + 64'd6) begin n_bad++; $display("FAIL cycle_inhibit: got %0d want %0d", cyc, cbase + 64'd6); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.mmio_en = 1'b1; bus.mmio_wen = 1'b1; bus.mmio_addr = 32'h102C; bus.mmio_wdata = 32'd9;
    @(negedge clk);
    sb_q.push_back('{name: "b2b_rd9", data: 32'd9, err: 1'b0});
    bus.mmio_wen = 1'b0;
    @(negedge clk);
    bus.mmio_wen = 1'b1; bus.mmio_wdata = 32'd11;
    @(negedge clk);
    n_cmp++; if (bus.mmio_rdata !== 32'd9) begin n_bad++; $display("FAIL b2b_prewrite: rdata=%h want 9", bus.mmio_rdata); end
    sb_q.push_back('{name: "b2b_rd11", data: 32'd11, err: 1'b0});
    bus.mmio_wen = 1'b0;
    @(negedge clk);
    bus.mmio_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    inh_tm = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    sb_q.push_back('{name: "mid_inflight", data: 32'd0, err: 1'b0});
    bus.mmio_en = 1'b1; bus.mmio_wen = 1'b0; bus.mmio_addr = 32'h1000;
    @(negedge clk);
    bus.mmio_en = 1'b0;
    n_cmp++; if (t !== 64'd0 || cyc !== 64'd0 || ins !== 64'd0) begin n_bad++; $display("FAIL mid_ctr: t=%h cyc=%h ins=%h want 0", t, cyc, ins); end
    n_cmp++; if (irq !== 2'b00) begin n_bad++; $display("FAIL mid_irq: got %b want 00", irq); end
    resetn = 1'b1; inh_tm = 1'b1;
    rd("mid_ctrl0",   32'h1018, 32'd1, 1'b0);
    rd("mid_period1", 32'h102C, 32'd0, 1'b0);
    rd("mid_cmp1_lo", 32'h1020, 32'hFFFF_FFFF, 1'b0);
  endtask

  initial begin
    bus.mmio_en = 1'b0; bus.mmio_wen = 1'b0; bus.mmio_addr = 32'd0; bus.mmio_wdata = 32'd0;
    test_reset();
    test_legacy();
    test_prescaler();
    test_periodic();
    test_collision();
    test_decode();
    test_wrap();
    test_counters();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d expectations never answered", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frv_timer_bank.md
# frv_timer_bank

Parametrised successor of the core counter block. Provides the `mtime` time base with a programmable prescaler and a bank of `NCMP` compare channels, each with one-shot or periodic (auto-reload) mode. Each channel has sticky pending bits and per-channel interrupt enables. Also keeps the `cycle`/`instret` CSR counters. Sits beside the CSR unit and answers its own MMIO window on the core's peripheral bus.

## Interface
Parameters:
- `MMIO_BASE_ADDR`, 32'h0000_1000, base of the MMIO window.
- `MMIO_BASE_MASK`, 32'hFFFF_F000, bits that select the window; offset = `mmio_addr & ~MASK`.
- `NCMP`, 2, number of compare channels, 1..8.
- `PRESCALE_W`, 8, width of the prescaler divisor register, 1..32.
- `MMIO_MTIMECMP_RESET`, all ones, reset value of every compare register.

Ports (one clock; reset is synchronous and active-low):
- `g_clk` in 1: global clock.
- `g_resetn` in 1: synchronous active-low reset.
- `instr_ret` in 1: instruction retired.
- `inhibit_cy` / `inhibit_tm` / `inhibit_ir` in 1 each: freeze cycle / time / instret.
- `timer_interrupt` out NCMP: per-channel `pending[i] & en[i]`, driven from registers.
- `ctr_time` out 64: equals `mtime`.
- `ctr_cycle` / `ctr_instret` out 64 each.
- `mmio_en`, `mmio_wen` in 1 each: access strobe and write qualifier.
- `mmio_addr`, `mmio_wdata` in 32 each.
- `mmio_rdata` out 32, registered.
- `mmio_error` out 1, registered.

## Operation
Register map (word offsets):
- 0x000 MTIME_LO; 0x004 MTIME_HI.
- 0x008 PRESCALE[PRESCALE_W-1:0].
- 0x00C STATUS[NCMP-1:0]: pending bits, write-1-to-clear.
- Channel i at 0x010+16*i:
  - +0 CMP_LO, +4 CMP_HI.
  - +8 CTRL: bit0 `en`, bit1 `periodic`.
  - +C PERIOD (32 bit).
- Any other offset, or `mmio_addr[1:0]!=0`, sets `mmio_error`. Error writes have no effect. Unimplemented bits read 0.

Time base:
- Prescale counter `pc` runs 0..PRESCALE.
- `tick` = (`pc==PRESCALE`) & !`inhibit_tm`. On tick, `mtime` increments and `pc` returns to 0.
- While `inhibit_tm`, `pc` holds. PRESCALE=0 gives one tick per cycle.
- An MTIME_LO/HI write replaces that half, beats any same-cycle increment, and clears `pc`. A PRESCALE write clears `pc`.
- `mtime` wraps 2^64-1 to 0.

Channel i:
- `match` = `en` & (`mtime >= cmp`), unsigned 64-bit compare.
- On `match`, `pending` is set on the next edge.
- If `periodic`, then on each cycle with `match`, `cmp <= cmp + {32'b0,PERIOD}` (mod 2^64).
- PERIOD=0 in periodic mode leaves `cmp` unchanged, so `pending` stays re-asserting.
- A CMP_LO/HI write replaces that half and clears `pending`. It also suppresses that cycle's set and reload; the new value is compared from the next cycle.
- STATUS W1C clear in the same cycle as a set: the set wins.
- Clearing `en` masks `timer_interrupt[i]` and stops new sets. An existing `pending` bit is retained.

Counters:
- `ctr_cycle` increments when !`inhibit_cy`.
- `ctr_instret` increments when `instr_ret` & !`inhibit_ir`.
- Both are read-only here.

Reset values:
- `mtime`, `pc`, PRESCALE, pending, PERIOD, `ctr_*`, `mmio_rdata`, `mmio_error`, `timer_interrupt`: all 0.
- `cmp`: `MMIO_MTIMECMP_RESET`.
- CTRL: ch0 = 0x1 (legacy behaviour, enabled one-shot); others 0.

## Timing
- MMIO: one access per `mmio_en` cycle with no stall.
- `mmio_rdata`/`mmio_error` update on the edge after `mmio_en` and hold while `mmio_en` is low.
- Read data is the pre-write register state of that cycle.
- Writes take effect on the edge of the `mmio_en` cycle.
- `mtime` reaching `cmp` → `pending` and `timer_interrupt` high one cycle later.
- A reloaded `cmp` is compared one cycle after the reload.
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight read returns 0.

## Structure
- Shared package: register offset constants, CTRL bit positions (`CTRL_EN`=0, `CTRL_PERIODIC`=1), channel stride (16), and the max-channel limit.
- Natural sub-module `frv_timer_cmp`, one per channel via generate. It holds `cmp`/CTRL/PERIOD/`pending` and takes `mtime`, decoded write strobes, wdata and the W1C bit.
- Top level holds `mtime`, prescaler, counters, address decode and the read mux.

## Test plan
- Legacy: PRESCALE=0, write ch0 CMP_LO=10, CMP_HI=0 after reset → `timer_interrupt[0]` rises the cycle after `mtime`=10. Writing CMP_LO=100 drops it the next cycle.
- Prescaler: PRESCALE=3, clear `mtime` → `mtime` increments every 4th cycle. Setting `inhibit_tm` for 5 cycles → `mtime` and `pc` frozen.
- Periodic: ch1 CTRL=0x3, PERIOD=5, CMP=20 → pending set at `mtime`=20; `cmp` reads back 25. W1C STATUS=0x2 → clear, then re-pend at 25.
- Collision: W1C on ch1 in the same cycle as a ch1 match → pending stays 1. CMP write with a match pending → pending 0.
- Decode: read 0x0A0 (NCMP=2) and 0x001 → `mmio_error`=1, `rdata`=0. Error write leaves all registers unchanged.
- Wrap: `mtime`=0xFFFF_FFFF_FFFF_FFFF, one tick → 0. `ctr_instret` counts only `instr_ret` cycles without `inhibit_ir`.
